// File: rtl/csb_cmd_sequencer_if.sv
// Command, CSB request, CSB response and host response channels of the CSB command sequencer.
// The master modport is the sequencer side; slave is the host/accelerator side.
interface csb_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdat;
    logic        cmd_write;
    logic        cmd_nposted;

    logic        csb2nvdla_valid;
    logic        csb2nvdla_ready;
    logic [15:0] csb2nvdla_addr;
    logic [31:0] csb2nvdla_wdat;
    logic        csb2nvdla_write;
    logic        csb2nvdla_nposted;

    logic        nvdla2csb_valid;
    logic [31:0] nvdla2csb_data;
    logic        nvdla2csb_wr_complete;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_is_write;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
        output cmd_ready,
        output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        input  csb2nvdla_ready,
        input  nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        output rsp_valid, rsp_data, rsp_is_write
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
        input  cmd_ready,
        input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        output csb2nvdla_ready,
        output nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        input  rsp_valid, rsp_data, rsp_is_write
    );
endinterface

// File: rtl/csb_cmd_sequencer.sv
// In-order CSB master: queues register commands, issues them on csb2nvdla_*, tracks
// outstanding reads/non-posted writes, returns responses and flags timeout/unexpected errors.
module csb_cmd_sequencer #(
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = 16
) (
    input  logic                              dla_csb_clk,
    input  logic                              dla_reset_rstn,
    csb_cmd_sequencer_if.master               bus,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              idle,
    output logic                              timeout_err,
    output logic                              unexp_err,
    input  logic                              err_clr
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int ENTRY_W = 16 + 32 + 1 + 1;

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Command queue storage (no reset so it maps onto RAM)
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic [15:0]        head_addr;
    logic [31:0]        head_wdat;
    logic               head_write, head_nposted, head_elig;

    // Request output registers
    logic [15:0] req_addr_reg;
    logic [31:0] req_wdat_reg;
    logic        req_write_reg, req_nposted_reg;
    logic        load;

    // Outstanding / response tracking
    logic [OUT_W-1:0] outstanding_reg, outstanding_next;
    logic [OUT_W-1:0] wr_pend_reg, wr_pend_next, wr_total;
    logic             hs, inc, rd_acc, wr_acc, emit_rd, emit_wr, unexp_evt, any_rsp;
    logic             rsp_valid_reg, rsp_is_write_reg;
    logic [31:0]      rsp_data_reg;

    // Timeout and error flags
    logic [CNT_W-1:0] to_cnt_reg, to_cnt_next;
    logic             timeout_evt;
    logic             timeout_err_reg, timeout_err_next;
    logic             unexp_err_reg, unexp_err_next;

    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);
    assign push  = bus.cmd_valid && !full;
    assign pop   = load;

    // nposted is meaningless for reads, so it is stored cleared for them
    assign push_entry = {bus.cmd_addr, bus.cmd_wdat, bus.cmd_write, bus.cmd_write & bus.cmd_nposted};
    assign head_entry = mem[rd_ptr_reg];
    assign head_addr    = head_entry[49:34];
    assign head_wdat    = head_entry[33:2];
    assign head_write   = head_entry[1];
    assign head_nposted = head_entry[0];

    always_ff @(posedge dla_csb_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Response acceptance: a response is legal only while something is outstanding
    assign rd_acc    = bus.nvdla2csb_valid && (outstanding_reg != '0);
    assign wr_acc    = bus.nvdla2csb_wr_complete && (outstanding_reg > OUT_W'(rd_acc));
    assign unexp_evt = (bus.nvdla2csb_valid && !rd_acc) || (bus.nvdla2csb_wr_complete && !wr_acc);
    assign any_rsp   = bus.nvdla2csb_valid || bus.nvdla2csb_wr_complete;

    assign hs  = (state_reg == ST_REQ) && bus.csb2nvdla_ready;
    assign inc = hs && (!req_write_reg || req_nposted_reg);

    assign outstanding_next = outstanding_reg + OUT_W'(inc) - OUT_W'(rd_acc) - OUT_W'(wr_acc);

    // Eligibility looks at the count after this cycle's handshake and responses
    assign head_elig = !empty && ((head_write && !head_nposted) || (outstanding_next < MAX_OUT));

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (head_elig) begin
                    state_next = ST_REQ;
                    load       = 1'b1;
                end
            end
            ST_REQ: begin
                if (hs) begin
                    if (head_elig) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read data always goes out first; completions carry no payload, so a count is enough to defer them
    always_comb begin
        wr_total     = wr_pend_reg + OUT_W'(wr_acc);
        emit_rd      = rd_acc;
        emit_wr      = !rd_acc && (wr_total != '0);
        wr_pend_next = wr_total - OUT_W'(emit_wr);
    end

    always_comb begin
        to_cnt_next = to_cnt_reg;
        timeout_evt = 1'b0;
        if ((outstanding_reg == '0) || any_rsp) begin
            to_cnt_next = '0;
        end else if (to_cnt_reg != TO_LIMIT) begin
            to_cnt_next = to_cnt_reg + CNT_W'(1);
            timeout_evt = (to_cnt_reg == TO_LAST);
        end
    end

    // A new error event beats a clear in the same cycle
    always_comb begin
        timeout_err_next = timeout_err_reg;
        unexp_err_next   = unexp_err_reg;
        if (err_clr) begin
            timeout_err_next = 1'b0;
            unexp_err_next   = 1'b0;
        end
        if (timeout_evt) begin
            timeout_err_next = 1'b1;
        end
        if (unexp_evt) begin
            unexp_err_next = 1'b1;
        end
    end

    always_ff @(posedge dla_csb_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            state_reg        <= ST_IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            req_addr_reg     <= '0;
            req_wdat_reg     <= '0;
            req_write_reg    <= 1'b0;
            req_nposted_reg  <= 1'b0;
            outstanding_reg  <= '0;
            wr_pend_reg      <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_data_reg     <= '0;
            rsp_is_write_reg <= 1'b0;
            to_cnt_reg       <= '0;
            timeout_err_reg  <= 1'b0;
            unexp_err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (load) begin
                req_addr_reg    <= head_addr;
                req_wdat_reg    <= head_wdat;
                req_write_reg   <= head_write;
                req_nposted_reg <= head_nposted;
            end
            outstanding_reg  <= outstanding_next;
            wr_pend_reg      <= wr_pend_next;
            rsp_valid_reg    <= emit_rd || emit_wr;
            rsp_data_reg     <= emit_rd ? bus.nvdla2csb_data : 32'h0;
            rsp_is_write_reg <= emit_wr;
            to_cnt_reg       <= to_cnt_next;
            timeout_err_reg  <= timeout_err_next;
            unexp_err_reg    <= unexp_err_next;
        end
    end

    assign bus.cmd_ready         = !full;
    assign bus.csb2nvdla_valid   = (state_reg == ST_REQ);
    assign bus.csb2nvdla_addr    = req_addr_reg;
    assign bus.csb2nvdla_wdat    = req_wdat_reg;
    assign bus.csb2nvdla_write   = req_write_reg;
    assign bus.csb2nvdla_nposted = req_nposted_reg;
    assign bus.rsp_valid         = rsp_valid_reg;
    assign bus.rsp_data          = rsp_data_reg;
    assign bus.rsp_is_write      = rsp_is_write_reg;

    assign outstanding = outstanding_reg;
    assign idle        = empty && (state_reg == ST_IDLE) && (outstanding_reg == '0);
    assign timeout_err = timeout_err_reg;
    assign unexp_err   = unexp_err_reg;
endmodule
